controller: RTL and testbench



---
 rtl/sap1_pkg.sv | 51 +++++
 rtl/ring_counter.sv | 32 +++
 rtl/controller.sv | 59 +++++
 tb/tb_controller.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared constants for the SAP-1 hardwired controller: opcodes, control-word
// bit positions, one-hot T-states and the fetch/execute control words.
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_LDI = 4'b0100;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam int CW_HLT     = 13;
    localparam int CW_PC_INC  = 12;
    localparam int CW_PC_OE   = 11;
    localparam int CW_MAR_LD  = 10;
    localparam int CW_RAM_OE  = 9;
    localparam int CW_RAM_WE  = 8;
    localparam int CW_IR_LD   = 7;
    localparam int CW_IR_OE   = 6;
    localparam int CW_A_LD    = 5;
    localparam int CW_A_OE    = 4;
    localparam int CW_ALU_SUB = 3;
    localparam int CW_ALU_OE  = 2;
    localparam int CW_B_LD    = 1;
    localparam int CW_OUT_LD  = 0;

    typedef enum logic [5:0] {
        T1 = 6'b000001,
        T2 = 6'b000010,
        T3 = 6'b000100,
        T4 = 6'b001000,
        T5 = 6'b010000,
        T6 = 6'b100000
    } t_state_e;

    localparam logic [13:0] CW_NONE     = 14'h0000;
    localparam logic [13:0] CW_FETCH_T1 = 14'h0C00;
    localparam logic [13:0] CW_FETCH_T2 = 14'h1000;
    localparam logic [13:0] CW_FETCH_T3 = 14'h0280;
    localparam logic [13:0] CW_IR_MAR   = 14'h0440;
    localparam logic [13:0] CW_RAM_A    = 14'h0220;
    localparam logic [13:0] CW_RAM_B    = 14'h0202;
    localparam logic [13:0] CW_ALU_ADD  = 14'h0024;
    localparam logic [13:0] CW_ALU_SUBW = 14'h002C;
    localparam logic [13:0] CW_A_RAM    = 14'h0110;
    localparam logic [13:0] CW_IR_A     = 14'h0060;
    localparam logic [13:0] CW_A_OUT    = 14'h0011;
    localparam logic [13:0] CW_HALT     = 14'h2000;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring counter T1..T6; hold freezes the current state and
// any illegal pattern falls back to T1 on the next edge.
module ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       hold,
    output logic [5:0] state
);

    t_state_e state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T1;
        end else if (!hold) begin
            case (state_q)
                T1:      state_q <= T2;
                T2:      state_q <= T3;
                T3:      state_q <= T4;
                T4:      state_q <= T5;
                T5:      state_q <= T6;
                T6:      state_q <= T1;
                default: state_q <= T1;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/controller.sv
// SAP-1 hardwired control unit: ring counter plus a combinational decoder that
// maps (T-state, opcode) to the 14-bit active-high control word.
module controller
    import sap1_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  opcode,
    output logic [13:0] cw_bus
);

    logic [5:0]  state;
    logic [13:0] cw;

    // HLT is only ever raised in T4, so feeding it back as hold parks the counter there.
    ring_counter u_ring (
        .clk   (clk),
        .rst   (rst),
        .hold  (cw[CW_HLT]),
        .state (state)
    );

    always_comb begin
        cw = CW_NONE;
        case (state)
            T1: cw = CW_FETCH_T1;
            T2: cw = CW_FETCH_T2;
            T3: cw = CW_FETCH_T3;
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: cw = CW_IR_MAR;
                    OP_LDI:  cw = CW_IR_A;
                    OP_OUT:  cw = CW_A_OUT;
                    OP_HLT:  cw = CW_HALT;
                    default: cw = CW_NONE;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA:         cw = CW_RAM_A;
                    OP_ADD, OP_SUB: cw = CW_RAM_B;
                    OP_STA:         cw = CW_A_RAM;
                    default:        cw = CW_NONE;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD:  cw = CW_ALU_ADD;
                    OP_SUB:  cw = CW_ALU_SUBW;
                    default: cw = CW_NONE;
                endcase
            end
            default: cw = CW_NONE;
        endcase
    end

    assign cw_bus = cw;

endmodule

// File: tb/tb_controller.sv
// Scoreboard bench for the SAP-1 controller: a T-state reference model predicts
// each control word, and a separate monitor pops and compares against cw_bus.
module tb_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  opcode;
    logic [13:0] cw_bus;

    int vectors;
    int miscompares;

    logic [13:0] exp_q[$];
    string       tag_q[$];
    event        stim_ev;

    int model_t;

    controller dut (
        .clk    (clk),
        .rst    (rst),
        .opcode (opcode),
        .cw_bus (cw_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference words straight from the instruction table, by mnemonic.
    function automatic logic [13:0] model_cw(input int t, input logic [3:0] op);
        logic [13:0] w;
        w = 14'h0000;
        if (t == 1) w = 14'h0C00;
        else if (t == 2) w = 14'h1000;
        else if (t == 3) w = 14'h0280;
        else begin
            case (op)
                4'd0:  w = (t == 4) ? 14'h0440 : (t == 5) ? 14'h0220 : 14'h0000;
                4'd1:  w = (t == 4) ? 14'h0440 : (t == 5) ? 14'h0202 : 14'h0024;
                4'd2:  w = (t == 4) ? 14'h0440 : (t == 5) ? 14'h0202 : 14'h002C;
                4'd3:  w = (t == 4) ? 14'h0440 : (t == 5) ? 14'h0110 : 14'h0000;
                4'd4:  w = (t == 4) ? 14'h0060 : 14'h0000;
                4'd14: w = (t == 4) ? 14'h0011 : 14'h0000;
                4'd15: w = (t == 4) ? 14'h2000 : 14'h0000;
                default: w = 14'h0000;
            endcase
        end
        return w;
    endfunction

    task automatic push_expect(input string tag);
        exp_q.push_back(model_cw(model_t, opcode));
        tag_q.push_back(tag);
        -> stim_ev;
    endtask

    // One clock: advance the model on the rising edge, then drive the new inputs.
    task automatic applyStimulus(input logic [3:0] op, input logic r, input string tag);
        @(posedge clk);
        if (rst) model_t = 1;
        else if (!(model_t == 4 && opcode == 4'd15)) model_t = (model_t == 6) ? 1 : model_t + 1;
        @(negedge clk);
        opcode = op;
        rst    = r;
        if (r) model_t = 1;
        push_expect(tag);
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int i = 0; i < 6; i++) applyStimulus(op, 1'b0, tag);
    endtask

    // Monitor: decoupled from stimulus, samples shortly after each drive event.
    initial begin
        logic [13:0] exp_w;
        string       tag;
        forever begin
            @(stim_ev);
            #1;
            if (exp_q.size() > 0) begin
                exp_w = exp_q.pop_front();
                tag   = tag_q.pop_front();
                checkOutput(tag, exp_w);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [13:0] exp_w);
        vectors++;
        if (cw_bus !== exp_w) begin
            miscompares++;
            $display("[TB] FAIL %s: cw_bus=%h expected=%h (t=T%0d op=%b)", tag, cw_bus, exp_w, model_t, opcode);
        end
        vectors++;
        if ($countones(cw_bus & 14'h0A54) > 1) begin
            miscompares++;
            $display("[TB] FAIL bus_drivers %s: drivers=%h expected at most one set", tag, cw_bus & 14'h0A54);
        end
    endtask

    initial begin
        logic [3:0] sweep[7];
        logic [3:0] rop;
        vectors     = 0;
        miscompares = 0;
        rst     = 1'b1;
        opcode  = 4'd0;
        model_t = 1;
        sweep = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd8, 4'd14};

        applyStimulus(4'd0, 1'b1, "reset");
        applyStimulus(4'd0, 1'b1, "reset");

        // LDA full instruction, then back into T1 and on to T5
        run_instr(4'd0, "lda");
        for (int i = 0; i < 5; i++) applyStimulus(4'd0, 1'b0, "lda2");

        // Reset mid-T5 with the clock running
        applyStimulus(4'd0, 1'b1, "rst_mid_t5");
        applyStimulus(4'd0, 1'b1, "rst_hold");
        for (int i = 0; i < 4; i++) applyStimulus(4'd1, 1'b0, "post_rst");
        applyStimulus(4'd1, 1'b0, "post_rst");
        applyStimulus(4'd1, 1'b0, "post_rst");

        foreach (sweep[k]) run_instr(sweep[k], $sformatf("sweep_%b", sweep[k]));

        // Opcode switch from ADD to SUB inside T6
        for (int i = 0; i < 6; i++) applyStimulus(4'd1, 1'b0, "add_t6");
        #3;
        opcode = 4'd2;
        push_expect("switch_t6");

        // Random instructions, with occasional opcode changes during execute
        for (int n = 0; n < 40; n++) begin
            rop = 4'($urandom_range(0, 14));
            for (int i = 0; i < 6; i++) begin
                if (i >= 3 && $urandom_range(0, 3) == 0) rop = 4'($urandom_range(0, 14));
                applyStimulus(rop, 1'b0, "random");
            end
        end

        // Halt: frozen in T4 until reset
        for (int i = 0; i < 4; i++) applyStimulus(4'd15, 1'b0, "hlt_enter");
        for (int i = 0; i < 22; i++) applyStimulus(4'd15, 1'b0, "hlt_hold");
        applyStimulus(4'd15, 1'b1, "hlt_reset");
        applyStimulus(4'd0, 1'b0, "after_hlt");
        applyStimulus(4'd0, 1'b0, "after_hlt");

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) #1;
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
